// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for bitwise_logic_pipe.
// out_count exists only when LOGIC_PIPE_COUNT_EN is defined.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic             out_zero;
`ifdef LOGIC_PIPE_COUNT_EN
    logic [15:0]      out_count;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_zero, out_count
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_zero, out_count
    );
`else
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_zero
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_zero
    );
`endif
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Pipelined eight-op bitwise logic unit with valid/ready flow control.
// Define LOGIC_PIPE_COUNT_EN to add the 16-bit accepted-result counter out_count.
module bitwise_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    bitwise_logic_pipe_if.slave bus
);
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] zero_p;
    logic [WIDTH-1:0]  res_p [STAGES];
    logic [STAGES-1:0] load_p;
    logic [WIDTH-1:0]  res_in;
    logic              acc;

    // Stage k may load when any stage from k to the output is empty, or the
    // consumer takes the head; built with an accumulator to keep the chain acyclic.
    always_comb begin
        load_p = '0;
        acc    = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc       = acc || !vld_p[k];
            load_p[k] = acc;
        end
    end

    assign res_in       = logic_op(bus.in_op, bus.in_a, bus.in_b);
    assign bus.in_ready = load_p[0];

    // Stage 0 captures the op result; later stages shift only valid entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p  <= '0;
            zero_p <= '0;
            for (int k = 0; k < STAGES; k++) res_p[k] <= '0;
        end else begin
            if (load_p[0]) begin
                vld_p[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    res_p[0]  <= res_in;
                    zero_p[0] <= (res_in == '0);
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load_p[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        res_p[k]  <= res_p[k-1];
                        zero_p[k] <= zero_p[k-1];
                    end
                end
            end
        end
    end

    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.out_r     = res_p[STAGES-1];
    assign bus.out_zero  = zero_p[STAGES-1];

`ifdef LOGIC_PIPE_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.out_count = count_q;
`endif
endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, pipelined bitwise logic unit: the multi-operation, multi-bit successor to the single-bit AND/NOT gate pair. It applies one of eight bitwise operations to two WIDTH-bit operands and carries results through STAGES registered stages under valid/ready flow control. It sits between an operand source, such as a register-file read port or a testbench driver, and a result consumer, and it is the logic-op building block for the ALU.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (1..64)
- STAGES, 2, number of pipeline register stages (1..4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  operands and op are valid this cycle
- in_ready  output  1  unit accepts input this cycle
- in_op  input  3  operation select (see Operation)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_r  output  WIDTH  result
- out_zero  output  1  out_r == 0
- out_count  output  16  accepted-result counter (present only with LOGIC_PIPE_COUNT_EN)

## Operation
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (~a, b ignored), 7 PASS A.
- Result is computed combinationally from in_* and registered into stage 0. out_* come directly from stage STAGES-1 registers; no combinational path from in_* to out_*.
- Each stage holds a valid bit, a WIDTH-bit result and a zero flag. out_zero is registered alongside the result, not recomputed at the output.
- Transfer on the input side: in_valid && in_ready. Transfer on the output side: out_valid && out_ready.
- Stage k advances when stage k+1 is empty or stage k+1 advances. The last stage advances when !out_valid or out_ready.
- in_ready = stage 0 empty or stage 0 advancing. The pipeline therefore holds STAGES entries, and full throughput is 1 result per cycle.
- Data is captured from in_op/in_a/in_b only on an input transfer. A stalled stage holds its contents stable.
- out_r, out_zero and out_valid must not change while out_valid && !out_ready.
- Ordering is strict FIFO; results are never dropped or duplicated.

## Timing
- Reset (rst_n=0 at a clk edge): all stage valid bits 0, data registers 0, so out_valid=0, out_r=0, out_zero=0 (data zeroed; out_zero is 0 because the entry is invalid). in_ready=1 the first cycle after reset deasserts. out_count=0.
- Reset mid-operation flushes all in-flight entries; nothing in flight emerges after reset.
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles after acceptance, assuming no backpressure.
- Full pipeline with out_ready=0: in_ready=0 the same cycle, combinational through the advance chain.
- Full pipeline with out_ready=1 and in_valid=1: simultaneous input and output transfer in the same cycle; occupancy unchanged.
- in_valid while in_ready=0: no transfer. The source must hold its inputs; the unit ignores them.
- Unused upper bits do not exist: every op is bitwise over exactly WIDTH bits, with no carries or sign handling.

## Configuration
- LOGIC_PIPE_COUNT_EN defined: out_count port present. It increments by 1 on every output transfer and wraps 0xFFFF -> 0x0000. It is reset to 0.
- Not defined: out_count port and its register are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_r=0, out_zero=0; in_ready=1 after release.
- Truth sweep, WIDTH=4, STAGES=2, out_ready=1: apply a=4'b0011, b=4'b0101 for ops 0..7 -> results 0001, 0111, 0110, 1110, 1000, 1001, 1100, 0011 in order, each 2 cycles after acceptance. AND result on a=0,b=F gives out_zero=1.
- Backpressure: WIDTH=32, STAGES=3. Stream 5 ops with out_ready=0 -> exactly 3 accepted, then in_ready=0 and out_r stable. Raise out_ready -> all 5 emerge in order, with no loss or duplication.
- Simultaneous in/out with full pipeline and both handshakes asserted for 10 cycles -> 10 accepted, 10 emitted, with occupancy constant at STAGES.
- Mid-stream reset: 2 entries in flight, then rst_n=0 for 1 cycle -> out_valid=0 next cycle, and the flushed entries never appear.
- With LOGIC_PIPE_COUNT_EN: emit 65537 results -> out_count=1 (wrapped).
